// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer_ctrl device: FSM states, register offsets,
// CTRL field positions, mode encodings and the memory-map windows.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } timer_state_e;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;

  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlModeMsb = 2;
  localparam int unsigned CtrlImBit   = 3;

  localparam logic [1:0] ModeOneShot = 2'd0;
  localparam logic [1:0] ModeReload  = 2'd1;

  // Also used by the memory-stage address exception check.
  localparam logic [31:0] Timer0Base  = 32'h0000_7f00;
  localparam logic [31:0] Timer0Limit = 32'h0000_7f0b;
  localparam logic [31:0] Timer1Base  = 32'h0000_7f10;
  localparam logic [31:0] Timer1Limit = 32'h0000_7f1b;

endpackage

// File: rtl/timer_ctrl_if.sv
// Word-wide register bus between the memory stage and a timer_ctrl instance.
interface timer_ctrl_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, output we, output din, input dout, input irq);
  modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_ctrl.sv
// Programmable interval timer: CTRL/PRESET/COUNT registers, countdown FSM and
// a maskable interrupt request.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  timer_ctrl_if.slave  bus
);

  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_flag_q, irq_flag_d;
  timer_state_e     state_q, state_d;

  logic       wr_ctrl, wr_preset, irq_set;
  logic [1:0] mode;

  assign wr_ctrl   = bus.we && (bus.addr == AddrCtrl);
  assign wr_preset = bus.we && (bus.addr == AddrPreset);
  assign mode      = ctrl_q[CtrlModeMsb:CtrlModeLsb];

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    state_d    = state_q;
    irq_set    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ctrl_q[CtrlEnBit]) state_d = StLoad;
      end
      StLoad: begin
        count_d    = preset_q;
        irq_flag_d = 1'b0;
        state_d    = StCnt;
      end
      StCnt: begin
        if (!ctrl_q[CtrlEnBit]) begin
          state_d = StIdle;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          count_d = '0;
          irq_set = 1'b1;
          state_d = StInt;
        end
      end
      StInt: begin
        if (mode == ModeReload) begin
          // Dropping the flag here keeps the auto-reload irq to one cycle.
          irq_flag_d = 1'b0;
          state_d    = StLoad;
        end else begin
          ctrl_d[CtrlEnBit] = 1'b0;
          state_d           = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Software writes override the hardware EN clear; a hardware set beats
    // the software clear of the flag.
    if (wr_ctrl)   ctrl_d   = bus.din[3:0];
    if (wr_preset) preset_d = bus.din[CNT_W-1:0];
    if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;
    if (irq_set) irq_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= StIdle;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    bus.dout = '0;
    unique case (bus.addr)
      AddrCtrl:   bus.dout = {28'd0, ctrl_q};
      AddrPreset: bus.dout = 32'(preset_q);
      AddrCount:  bus.dout = 32'(count_q);
      default:    bus.dout = '0;
    endcase
  end

  assign bus.irq = ctrl_q[CtrlImBit] & irq_flag_q;

endmodule
